// File: rtl/clock_gate_arbiter_pkg.sv
// Shared state encodings and parameter defaults for the clock-gate arbiter.
`ifndef CLOCK_GATE_ARBITER_PKG_SV
`define CLOCK_GATE_ARBITER_PKG_SV
package clock_gate_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int BURST_DEF = 4;
    localparam int CNT_W_DEF = 3;

endpackage
`endif

// File: rtl/clock_gate_arbiter_enabler.sv
// Clock gate cell: en must only change while clk is low for a clean eclk.
module enabler (
    input  logic clk,
    input  logic en,
    output logic eclk
);

    assign eclk = clk & en;

endmodule

// File: rtl/clock_gate_arbiter_rr_pick.sv
// Round-robin pick: first set req bit searching upward from ptr, wrapping at N_REQ-1.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [IW:0]   pos;
    logic [IW-1:0] sel;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = '0;
        sel    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N_REQ)) pos = pos - (IW+1)'(N_REQ);
            sel = pos[IW-1:0];
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_gate_arbiter.sv
// Round-robin arbiter issuing bounded bursts of gated clock pulses to N_REQ requesters.
module clock_gate_arbiter
    import clock_gate_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int BURST = BURST_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] enb,
    output logic [N_REQ-1:0] eclk,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] enb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    idx_q;

    logic [N_REQ-1:0] winner;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             held;
    logic [IW-1:0]    ptr_d;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++)
            if (winner[k]) win_idx = IW'(k);
    end

    // Only the granted bit matters during GRANT; other requests wait for GAP.
    assign held  = |(req & gnt_q);
    assign ptr_d = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    cnt_q <= '0;
                    if (win_vld) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= winner;
                        idx_q   <= win_idx;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!held || cnt_q == CNT_LAST) begin
                        state_q <= ST_GAP;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= ptr_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Enables move on the falling edge so the AND gate never sees a change while clk is high.
    always_ff @(negedge clk or negedge reset_L) begin
        if (!reset_L) enb_q <= '0;
        else          enb_q <= gnt_q;
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_gate
        enabler u_en (
            .clk  (clk),
            .en   (enb_q[g]),
            .eclk (eclk[g])
        );
    end

    assign gnt  = gnt_q;
    assign enb  = enb_q;
    assign busy = (state_q != ST_IDLE);
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_clock_gate_arbiter.sv
// Scoreboard bench: expected eclk bursts are queued at stimulus time, popped as bursts end.
module tb_clock_gate_arbiter;

    localparam int N = 4;
    localparam int B = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt, enb, eclk;
    logic          busy;
    logic [CW-1:0] cnt;

    typedef struct {
        int idx;
        int len;
        bit gapchk;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    clock_gate_arbiter #(.N_REQ(N), .BURST(B), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .req     (req),
        .gnt     (gnt),
        .enb     (enb),
        .eclk    (eclk),
        .busy    (busy),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int len, input bit gapchk);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gapchk = gapchk;
        sbq.push_back(e);
    endtask

    // enables may only move while clk is low (reset excepted); grants never overlap
    always @(enb) if (reset_L === 1'b1) chk("enb_edge_clk", clk, 0);
    always @(negedge clk) chk("gnt_onehot", ($countones(gnt) <= 1), 1);

    // burst monitor: run length of eclk high phases per requester
    int run_len[N];
    int run_gap[N];
    int idle_n = 0;

    initial for (int i = 0; i < N; i++) begin
        run_len[i] = 0;
        run_gap[i] = 0;
    end

    always @(posedge clk) begin
        #1;
        if (eclk == '0) idle_n++;
        for (int i = 0; i < N; i++) begin
            if (eclk[i]) begin
                if (run_len[i] == 0) run_gap[i] = idle_n;
                run_len[i]++;
            end else if (run_len[i] != 0) begin
                if (sbq.size() == 0) begin
                    chk("sb_extra_run", i, 99);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("run_idx", i, e.idx);
                    chk("run_len", run_len[i], e.len);
                    if (e.gapchk) chk("run_gap", run_gap[i], 1);
                end
                run_len[i] = 0;
            end
        end
        if (eclk != '0) idle_n = 0;
    end

    initial begin
        int rot[4];
        logic [N-1:0] eg;
        rot = '{0, 1, 3, 0};
        reset_L = 1'b0;
        req = '1;

        // held in reset with all requests up
        repeat (4) begin
            at_pos();
            chk("rst_gnt", gnt, 0);
            chk("rst_enb", enb, 0);
            chk("rst_eclk", eclk, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cnt", cnt, 0);
        end
        @(negedge clk);
        req = '0;
        reset_L = 1'b1;
        at_pos();
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);

        // rotation 0,1,3,0
        @(negedge clk);
        req = 4'b1011;
        push(0, 4, 0); push(1, 4, 1); push(3, 4, 1); push(0, 4, 1);
        for (int k = 0; k < 20; k++) begin
            at_pos();
            eg = 4'b0001 << rot[k / 5];
            chk("rot_gnt", gnt, (k % 5 == 4) ? 0 : eg);
            chk("rot_cnt", cnt, (k % 5 == 4) ? 0 : k % 5);
            chk("rot_busy", busy, 1);
        end
        @(negedge clk);
        req = '0;
        repeat (3) at_pos();
        chk("rot_idle", busy, 0);

        // single requester: burst, one gap, re-grant
        @(negedge clk);
        req = 4'b0100;
        push(2, 4, 0); push(2, 4, 1);
        for (int k = 0; k < 10; k++) begin
            at_pos();
            chk("burst_gnt", gnt, (k % 5 == 4) ? 0 : 4'b0100);
            chk("burst_cnt", cnt, (k % 5 == 4) ? 0 : k % 5);
        end
        @(negedge clk);
        req = '0;
        repeat (3) at_pos();
        chk("burst_idle", busy, 0);

        // early release of requester 1
        @(negedge clk);
        req = 4'b0010;
        push(1, 2, 0);
        at_pos();
        chk("early_gnt", gnt, 4'b0010);
        at_pos();
        chk("early_cnt", cnt, 1);
        @(negedge clk);
        req = '0;
        at_pos();
        chk("early_gap_gnt", gnt, 0);
        chk("early_gap_busy", busy, 1);
        chk("early_gap_cnt", cnt, 0);
        at_pos();
        chk("early_idle", busy, 0);
        at_pos();

        // pointer now at 2; reset lands mid-grant at cnt = 2
        @(negedge clk);
        req = 4'b1111;
        push(2, 2, 0);
        at_pos();
        chk("ptr_after_early", gnt, 4'b0100);
        at_pos();
        at_pos();
        chk("mid_cnt", cnt, 2);
        chk("mid_eclk_hi", eclk, 4'b0100);
        #1;
        reset_L = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_enb", enb, 0);
        chk("mid_rst_eclk", eclk, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", cnt, 0);
        at_pos();
        chk("mid_rst_hold", gnt, 0);
        @(negedge clk);
        reset_L = 1'b1;
        push(0, 1, 0);
        at_pos();
        chk("restart_req0", gnt, 4'b0001);
        @(negedge clk);
        req = '0;
        at_pos();
        chk("restart_gap", gnt, 0);
        repeat (4) at_pos();
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/clock_gate_arbiter.md
CLOCK_GATE_ARBITER -- requirements
Module: clock_gate_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the gated register bank.
REQ-002 SHALL have parameter BURST, default 4, maximum gated clock pulses per grant.
REQ-003 SHALL have parameter CNT_W, default 3, burst counter width, with 2^CNT_W >= BURST.
REQ-004 SHALL have port clk, input, 1, single system clock.
REQ-005 SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_REQ, per-requester access request, level-held.
REQ-007 SHALL have port gnt, output, N_REQ, one-hot grant, posedge-registered.
REQ-008 SHALL have port enb, output, N_REQ, gate enables, negedge-registered copy of gnt.
REQ-009 SHALL have port eclk, output, N_REQ, gated clocks, eclk[i] = clk AND enb[i].
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port cnt, output, CNT_W, pulses issued in the current grant.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and GAP, updated on posedge clk.
REQ-013 SHALL, in IDLE or GAP with any req bit high, go to GRANT, set gnt to the round-robin winner and set cnt = 0.
REQ-014 SHALL select the round-robin winner as the first set req bit searching upward from pointer ptr, wrapping from N_REQ-1 to 0.
REQ-015 SHALL, in IDLE with req == 0, remain in IDLE; in GAP with req == 0, go to IDLE.
REQ-016 SHALL, in GRANT, increment cnt by 1 each posedge while the granted req bit is high and cnt < BURST-1.
REQ-017 SHALL, in GRANT, go to GAP with gnt = 0 when cnt == BURST-1 or when the granted req bit is sampled low (early release).
REQ-018 SHALL, on leaving GRANT, set ptr = (granted index + 1) mod N_REQ.
REQ-019 SHALL spend exactly one cycle in GAP with gnt = 0, guaranteeing one dead cycle between grants.
REQ-020 SHALL keep gnt one-hot or zero at all times; two requesters shall never be granted together.
REQ-021 SHALL register enb[i] from gnt[i] on negedge clk, so enb changes only while clk is low and eclk is glitch-free.
REQ-022 SHALL, for an uninterrupted grant issued at posedge t0, produce exactly BURST eclk high phases, in cycles t0+1 through t0+BURST.
REQ-023 SHALL ignore requests that change during GRANT except the granted bit; a new req from another requester waits for GAP.
REQ-024 SHALL, in GRANT, hold cnt when no transition occurs; cnt returns to 0 in GAP and IDLE.

Reset
REQ-025 SHALL, on reset_L low, immediately and asynchronously force state = IDLE, gnt = 0, enb = 0, cnt = 0, ptr = 0 and busy = 0.
REQ-026 SHALL, on reset assertion mid-GRANT, stop eclk within the same low reset interval, with no partial pulse after reset_L falls.
REQ-027 SHALL, after reset_L rises, evaluate the first arbitration at the next posedge clk.

Structure
REQ-028 SHALL keep state encodings (IDLE = 2'b00, GRANT = 2'b01, GAP = 2'b10) and parameter defaults in a shared include file guarded by `ifndef.
REQ-029 SHALL contain one new combinational sub-module, rr_pick (inputs req, ptr; outputs one-hot winner and valid).
REQ-030 SHALL instantiate the existing enabler module N_REQ times to form eclk from clk and enb.

Verification
REQ-031 SHALL cover reset: with reset_L = 0 and req = 4'b1111, gnt = 0, enb = 0, eclk = 0 and busy = 0 throughout.
REQ-032 SHALL cover a single burst: req = 4'b0100 held -> gnt = 4'b0100, 4 eclk[2] pulses, one GAP cycle, then a re-grant to 2.
REQ-033 SHALL cover rotation: req = 4'b1011 held -> grant order 0, 1, 3, 0, each with 4 pulses and a 1-cycle gap between grants.
REQ-034 SHALL cover early release: req[1] dropped after 2 pulses -> GAP on the next posedge with exactly 2 eclk[1] pulses, and ptr moves to 2.
REQ-035 SHALL cover reset mid-GRANT: reset_L pulsed low at cnt = 2 -> gnt, enb and eclk go to 0 immediately, and arbitration restarts from requester 0.
REQ-036 SHALL cover glitch-freedom: a checker confirms enb toggles only when clk = 0 and popcount(gnt) <= 1 every cycle.
